// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU bundle for alu_share_arbiter.
// slave is the arbiter's view; master is the requester + ALU side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_ctrl;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_ctrl;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp0_err;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;
  logic             rsp1_err;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_err,
    output rsp1_valid, rsp1_data, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output alu_ctrl, alu_a, alu_b,
    input  alu_result,
    output busy, ops_done
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_err,
    input  rsp1_valid, rsp1_data, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  alu_ctrl, alu_a, alu_b,
    output alu_result,
    input  busy, ops_done
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters:
// IDLE grants and registers operands, EXEC captures the result, RESP returns it.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic             owner_q;
  logic             last_grant_q;
  logic             err_pend_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [3:0]       alu_ctrl_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [CNT_W-1:0] ops_done_q;

  logic             grant0;
  logic             grant1;
  logic [3:0]       win_ctrl;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             rsp_fire;

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0101, 4'b0110, 4'b1000, 4'b1001: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    // On a tie the port that did not win last time is served.
    if (!reset && state_q == IDLE) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
  end

  assign win_ctrl = grant1 ? bus.req1_ctrl : bus.req0_ctrl;
  assign win_a    = grant1 ? bus.req1_a    : bus.req0_a;
  assign win_b    = grant1 ? bus.req1_b    : bus.req0_b;
  assign rsp_fire = (state_q == RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_pend_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      alu_ctrl_q   <= 4'b0000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      ops_done_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            // Illegal codes leave the ALU inputs untouched and just flag the response.
            if (is_legal(win_ctrl)) begin
              alu_ctrl_q <= win_ctrl;
              alu_a_q    <= win_a;
              alu_b_q    <= win_b;
              err_pend_q <= 1'b0;
            end else begin
              err_pend_q <= 1'b1;
            end
            owner_q      <= grant1;
            last_grant_q <= grant1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q <= err_pend_q ? '0 : bus.alu_result;
          rsp_err_q  <= err_pend_q;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            ops_done_q <= ops_done_q + 1'b1;
            err_pend_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
  assign bus.rsp0_data  = bus.rsp0_valid ? rsp_data_q : '0;
  assign bus.rsp1_data  = bus.rsp1_valid ? rsp_data_q : '0;
  assign bus.rsp0_err   = bus.rsp0_valid && rsp_err_q;
  assign bus.rsp1_err   = bus.rsp1_valid && rsp_err_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: an operation-level reference model predicts grants,
// results and counters; a second instance with a 2-bit counter exercises wrap-around.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(W), .CNT_W(16)) bus ();
  alu_share_arbiter_if #(.WIDTH(W), .CNT_W(2))  bus2 ();

  alu_share_arbiter #(.WIDTH(W), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  alu_share_arbiter #(.WIDTH(W), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Reference ALU behaviour; illegal codes return junk so a missing zeroing shows up.
  function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a | b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd8:    return W'($signed(a) >>> b[4:0]);
      4'd9:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return a ^ b ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.alu_result  = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  assign bus2.alu_result = alu_fn(bus2.alu_ctrl, bus2.alu_a, bus2.alu_b);

  assign bus2.req0_valid = bus.req0_valid;
  assign bus2.req0_ctrl  = bus.req0_ctrl;
  assign bus2.req0_a     = bus.req0_a;
  assign bus2.req0_b     = bus.req0_b;
  assign bus2.req1_valid = bus.req1_valid;
  assign bus2.req1_ctrl  = bus.req1_ctrl;
  assign bus2.req1_a     = bus.req1_a;
  assign bus2.req1_b     = bus.req1_b;
  assign bus2.rsp0_ready = bus.rsp0_ready;
  assign bus2.rsp1_ready = bus.rsp1_ready;

  logic [15:0] legal_mask = 16'h036F;

  int          n_vec  = 0;
  int          n_miss = 0;
  bit          last_m;
  int unsigned ops_m;
  logic [3:0]  ctrl_m;
  logic [W-1:0] a_m, b_m;

  task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_m = 1'b1;
    ops_m  = 0;
    ctrl_m = 4'd0;
    a_m    = '0;
    b_m    = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_b({tag, "_busy"},   bus.busy, 1'b0);
    check_b({tag, "_rdy0"},   bus.req0_ready, 1'b0);
    check_b({tag, "_rdy1"},   bus.req1_ready, 1'b0);
    check_b({tag, "_rv0"},    bus.rsp0_valid, 1'b0);
    check_b({tag, "_rv1"},    bus.rsp1_valid, 1'b0);
    check_w({tag, "_rd0"},    bus.rsp0_data, '0);
    check_b({tag, "_re1"},    bus.rsp1_err, 1'b0);
    check_w({tag, "_actrl"},  W'(bus.alu_ctrl), '0);
    check_w({tag, "_aa"},     bus.alu_a, '0);
    check_w({tag, "_ab"},     bus.alu_b, '0);
    check_w({tag, "_ops"},    W'(bus.ops_done), '0);
  endtask

  // One full operation: arbitration, EXEC, RESP with bp cycles of backpressure, accept.
  task automatic transact(input bit v0, input bit v1,
                          input logic [3:0] c0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [3:0] c1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input int bp);
    bit           w;
    bit           ee;
    logic [3:0]   c;
    logic [W-1:0] a, b, ed;
    bus.req0_valid = v0; bus.req0_ctrl = c0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_ctrl = c1; bus.req1_a = a1; bus.req1_b = b1;
    #1;
    w = (v0 && v1) ? !last_m : v1;
    check_b("arb_rdy0", bus.req0_ready, v0 && !w);
    check_b("arb_rdy1", bus.req1_ready, v1 && w);
    check_b("arb_busy", bus.busy, 1'b0);
    c  = w ? c1 : c0;
    a  = w ? a1 : a0;
    b  = w ? b1 : b0;
    ee = !legal_mask[c];
    ed = ee ? '0 : alu_fn(c, a, b);
    if (!ee) begin
      ctrl_m = c; a_m = a; b_m = b;
    end
    last_m = w;

    tick();
    if (w) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    #1;
    check_b("exec_busy", bus.busy, 1'b1);
    check_b("exec_rdy0", bus.req0_ready, 1'b0);
    check_b("exec_rdy1", bus.req1_ready, 1'b0);
    check_b("exec_rv",   bus.rsp0_valid | bus.rsp1_valid, 1'b0);
    check_w("exec_actrl", W'(bus.alu_ctrl), W'(ctrl_m));
    check_w("exec_aa",    bus.alu_a, a_m);
    check_w("exec_ab",    bus.alu_b, b_m);

    tick();
    for (int k = 0; k <= bp; k++) begin
      check_b("resp_v0", bus.rsp0_valid, !w);
      check_b("resp_v1", bus.rsp1_valid, w);
      check_w("resp_data", w ? bus.rsp1_data : bus.rsp0_data, ed);
      check_b("resp_err",  w ? bus.rsp1_err  : bus.rsp0_err,  ee);
      check_w("resp_other_data", w ? bus.rsp0_data : bus.rsp1_data, '0);
      check_b("resp_rdy", bus.req0_ready | bus.req1_ready, 1'b0);
      if (k == bp) begin
        if (w) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
      end
      tick();
    end
    ops_m++;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    check_b("done_rv", bus.rsp0_valid | bus.rsp1_valid, 1'b0);
    check_b("done_busy", bus.busy, 1'b0);
    check_w("ops_done", W'(bus.ops_done), W'(ops_m % 65536));
    check_w("ops_wrap", W'(bus2.ops_done), W'(ops_m % 4));
  endtask

  // Assert reset while an operation is in EXEC (phase 0) or RESP (phase 1).
  task automatic reset_during(input int phase);
    bus.req0_valid = 1'b1; bus.req0_ctrl = 4'd1; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
    bus.req1_valid = 1'b1; bus.req1_ctrl = 4'd3; bus.req1_a = 32'd4; bus.req1_b = 32'd8;
    #1;
    tick();
    if (phase == 1) tick();
    check_b("pre_reset_busy", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_outputs(phase == 0 ? "rst_exec" : "rst_resp");
    model_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_b("post_reset_rv", bus.rsp0_valid | bus.rsp1_valid, 1'b0);
      check_b("post_reset_busy", bus.busy, 1'b0);
    end
  endtask

  initial begin
    bit          v0, v1;
    logic [3:0]  c0, c1;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_ctrl = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_ctrl = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    model_reset();
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Idle with nobody requesting: no ready.
    check_b("idle_rdy", bus.req0_ready | bus.req1_ready, 1'b0);

    // Port 0 alone: 5 + 7.
    transact(1'b1, 1'b0, 4'b0001, 32'd5, 32'd7, 4'b0000, '0, '0, 0);

    // Illegal code on port 1.
    transact(1'b0, 1'b1, 4'b0000, '0, '0, 4'b0100, 32'h1234, 32'h5678, 0);

    // Backpressure on port 0 with port 1 waiting, then port 1 served next.
    transact(1'b1, 1'b1, 4'b0010, 32'd100, 32'd1, 4'b0011, 32'hF0, 32'h0F, 10);
    transact(1'b0, 1'b1, 4'b0000, '0, '0, 4'b0011, 32'hF0, 32'h0F, 0);

    reset_during(0);
    reset_during(1);

    // Ties after reset: p0, p1, p0, then two more for the counter wrap.
    for (int k = 0; k < 5; k++)
      transact(1'b1, 1'b1, 4'b0010, 32'd10, 32'd3, 4'b1001, 32'hFFFF_FFFF, 32'd1, k % 2);

    for (int k = 0; k < 150; k++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      c0 = 4'($urandom_range(0, 15));
      c1 = 4'($urandom_range(0, 15));
      transact(v0, v1, c0, $urandom, $urandom, c1, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
